// File: rtl/usb_reg_spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: FSM states, FIFO address, CMD byte layout.
package usb_reg_spi_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_DUMMY,
      ST_WDATA,
      ST_RDATA,
      ST_DRAIN
   } state_t;

   localparam logic [3:0] FIFO_ADDR_DEFAULT = 4'd8;

   localparam int CMD_WRITE_BIT = 7;
   localparam int CMD_ADDR_MSB  = 3;
   localparam int CMD_ADDR_LSB  = 0;

endpackage

// File: rtl/usb_reg_spi_bridge_spi_sync_edge.sv
// Synchronises the asynchronous SPI pins into clk_i and produces single-cycle edge pulses.
// Edge pulses are held off after reset until the chain has refilled from the pins, so a
// chip select that was already low when reset released never looks like a new frame start.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi_sync
);

   localparam int CW = $clog2(SYNC_STAGES + 2);

   logic [SYNC_STAGES-1:0] sclk_chain;
   logic [SYNC_STAGES-1:0] cs_chain;
   logic [SYNC_STAGES-1:0] mosi_chain;
   logic                   sclk_prev;
   logic                   cs_prev;
   logic [CW-1:0]          flush_cnt;
   logic                   flushed;

   // Synchroniser chains plus one extra sample of SCLK and CS_N for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_chain <= '0;
         cs_chain   <= '1;
         mosi_chain <= '0;
         sclk_prev  <= 1'b0;
         cs_prev    <= 1'b1;
      end else begin
         sclk_chain <= {sclk_chain[SYNC_STAGES-2:0], sclk};
         cs_chain   <= {cs_chain[SYNC_STAGES-2:0], cs_n};
         mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
         sclk_prev  <= sclk_chain[SYNC_STAGES-1];
         cs_prev    <= cs_chain[SYNC_STAGES-1];
      end
   end

   // Counts the cycles needed for real pin values to reach both edge-detect samples
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flush_cnt <= '0;
      end else if (!flushed) begin
         flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign flushed   = (flush_cnt == CW'(SYNC_STAGES + 1));
   assign sclk_rise = flushed &  sclk_chain[SYNC_STAGES-1] & ~sclk_prev;
   assign sclk_fall = flushed & ~sclk_chain[SYNC_STAGES-1] &  sclk_prev;
   assign cs_fall   = flushed & ~cs_chain[SYNC_STAGES-1]   &  cs_prev;
   assign cs_rise   = flushed &  cs_chain[SYNC_STAGES-1]   & ~cs_prev;
   assign mosi_sync = mosi_chain[SYNC_STAGES-1];

endmodule

// File: rtl/usb_reg_spi_bridge.sv
// SPI mode-0 slave that turns CMD/LEN framed transfers into register-block read/write strobes.
module usb_reg_spi_bridge
   import usb_reg_spi_bridge_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] FIFO_ADDR   = FIFO_ADDR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        spi_sclk_i,
   input  logic        spi_cs_n_i,
   input  logic        spi_mosi_i,
   output logic        spi_miso_o,
   output logic        spi_irq_n_o,
   output logic        m_sel_o,
   output logic [3:0]  m_addr_o,
   output logic [31:0] m_data_o,
   output logic        m_rd_o,
   output logic        m_wr_o,
   input  logic [31:0] m_data_i,
   input  logic        m_intr_i
);

   state_t      state, next_state;
   logic        sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
   logic [2:0]  bit_cnt;
   logic [6:0]  shift_in;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte;
   logic        is_write;
   logic [7:0]  groups_left;
   logic [1:0]  byte_idx;
   logic [1:0]  last_idx;
   logic [23:0] word_acc;
   logic [31:0] rd_word;
   logic [31:0] shadow;
   logic [31:0] fetch_word;
   logic        is_fifo;
   logic        byte_done;
   logic        group_done;
   logic        last_group;
   logic        rd_strobe;
   logic        wr_pulse;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .sclk      (spi_sclk_i),
      .cs_n      (spi_cs_n_i),
      .mosi      (spi_mosi_i),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .mosi_sync (mosi_s)
   );

   // FIFO reads are normalised so the byte to send is always in the top byte of the word
   assign is_fifo    = (m_addr_o == FIFO_ADDR);
   assign last_idx   = is_fifo ? 2'd0 : 2'd3;
   assign fetch_word = is_fifo ? {m_data_i[7:0], 24'h000000} : m_data_i;
   assign rx_byte    = {shift_in, mosi_s};
   assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
   assign group_done = byte_done && (byte_idx == last_idx);
   assign last_group = (groups_left == 8'd1);

   assign m_rd_o  = rd_strobe;
   assign m_wr_o  = wr_pulse;
   assign m_sel_o = rd_strobe | wr_pulse;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the read strobe, which must coincide with the sampling edge
   always_comb begin
      next_state = state;
      rd_strobe  = 1'b0;
      if (cs_rise) begin
         next_state = ST_IDLE;
      end else if (cs_fall) begin
         next_state = ST_CMD;
      end else begin
         case (state)
            ST_CMD: begin
               if (byte_done) next_state = ST_LEN;
            end
            ST_LEN: begin
               if (byte_done) begin
                  next_state = is_write ? ST_WDATA : ST_DUMMY;
                  rd_strobe  = !is_write;
               end
            end
            ST_DUMMY: begin
               if (byte_done) next_state = ST_RDATA;
            end
            ST_RDATA: begin
               if (sclk_rise && (bit_cnt == 3'd0) && (byte_idx == last_idx) && !last_group) begin
                  rd_strobe = 1'b1;
               end
               if (group_done && last_group) next_state = ST_DRAIN;
            end
            ST_WDATA: begin
               if (group_done && last_group) next_state = ST_DRAIN;
            end
            default: next_state = state;
         endcase
      end
   end

   // Bit/byte/group counters, shift registers, MISO driver and register-side outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bit_cnt     <= 3'd0;
         shift_in    <= 7'd0;
         tx_byte     <= 8'd0;
         is_write    <= 1'b0;
         groups_left <= 8'd0;
         byte_idx    <= 2'd0;
         word_acc    <= 24'd0;
         rd_word     <= 32'd0;
         shadow      <= 32'd0;
         wr_pulse    <= 1'b0;
         spi_miso_o  <= 1'b0;
         spi_irq_n_o <= 1'b1;
         m_addr_o    <= 4'd0;
         m_data_o    <= 32'd0;
      end else begin
         spi_irq_n_o <= ~m_intr_i;
         wr_pulse    <= 1'b0;
         if (cs_fall || cs_rise) begin
            bit_cnt     <= 3'd0;
            byte_idx    <= 2'd0;
            word_acc    <= 24'd0;
            tx_byte     <= 8'd0;
            rd_word     <= 32'd0;
            shadow      <= 32'd0;
            groups_left <= 8'd0;
            spi_miso_o  <= 1'b0;
         end else if (state != ST_IDLE) begin
            if (sclk_rise) begin
               bit_cnt  <= bit_cnt + 3'd1;
               shift_in <= rx_byte[6:0];
            end
            if (sclk_fall) begin
               spi_miso_o <= tx_byte[3'd7 - bit_cnt];
            end
            if (rd_strobe && (state == ST_RDATA)) begin
               shadow <= fetch_word;
            end
            if (byte_done) begin
               case (state)
                  ST_CMD: begin
                     is_write <= rx_byte[CMD_WRITE_BIT];
                     m_addr_o <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                     tx_byte  <= 8'd0;
                  end
                  ST_LEN: begin
                     groups_left <= (rx_byte == 8'd0) ? 8'd1 : rx_byte;
                     byte_idx    <= 2'd0;
                     word_acc    <= 24'd0;
                     if (!is_write) begin
                        tx_byte <= {m_intr_i, 7'h00};
                        rd_word <= fetch_word;
                     end
                  end
                  ST_DUMMY: begin
                     tx_byte <= rd_word[31:24];
                     rd_word <= {rd_word[23:0], 8'h00};
                  end
                  ST_RDATA: begin
                     if (byte_idx != last_idx) begin
                        tx_byte  <= rd_word[31:24];
                        rd_word  <= {rd_word[23:0], 8'h00};
                        byte_idx <= byte_idx + 2'd1;
                     end else if (!last_group) begin
                        tx_byte     <= shadow[31:24];
                        rd_word     <= {shadow[23:0], 8'h00};
                        byte_idx    <= 2'd0;
                        groups_left <= groups_left - 8'd1;
                     end else begin
                        tx_byte     <= 8'd0;
                        groups_left <= 8'd0;
                     end
                  end
                  ST_WDATA: begin
                     if (byte_idx == last_idx) begin
                        m_data_o    <= {word_acc, rx_byte};
                        wr_pulse    <= 1'b1;
                        word_acc    <= 24'd0;
                        byte_idx    <= 2'd0;
                        groups_left <= groups_left - 8'd1;
                     end else begin
                        word_acc <= {word_acc[15:0], rx_byte};
                        byte_idx <= byte_idx + 2'd1;
                     end
                  end
                  default: tx_byte <= 8'd0;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_reg_spi_bridge.sv
// Self-checking bench for usb_reg_spi_bridge: an SPI master model, a register block with a
// byte FIFO at address 8, and frame-level expectations derived from the framing rules.
module tb_usb_reg_spi_bridge;

   localparam int HALF = 6;

   logic        clk;
   logic        rst;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_irq_n;
   logic        m_sel;
   logic [3:0]  m_addr;
   logic [31:0] m_wdata;
   logic        m_rd;
   logic        m_wr;
   logic [31:0] m_rdata;
   logic        m_intr;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs [16];
   logic [7:0]  fifo_mem [256];
   int          fifo_ptr = 0;
   logic        rd_pending = 1'b0;
   logic        prev_strobe = 1'b0;

   logic [7:0]  tx_q [$];
   logic [7:0]  rx_q [$];
   logic [35:0] wr_q [$];
   logic [3:0]  rd_addr_q [$];

   usb_reg_spi_bridge dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .spi_sclk_i  (spi_sclk),
      .spi_cs_n_i  (spi_cs_n),
      .spi_mosi_i  (spi_mosi),
      .spi_miso_o  (spi_miso),
      .spi_irq_n_o (spi_irq_n),
      .m_sel_o     (m_sel),
      .m_addr_o    (m_addr),
      .m_data_o    (m_wdata),
      .m_rd_o      (m_rd),
      .m_wr_o      (m_wr),
      .m_data_i    (m_rdata),
      .m_intr_i    (m_intr)
   );

   // 50 MHz-ish system clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Register block read port: FIFO head at address 8 (upper bits deliberately junk)
   assign m_rdata = (m_addr == 4'd8) ? {24'hA5A5A5, fifo_mem[fifo_ptr[7:0]]} : regs[m_addr];

   // Strobe monitor: logs transactions and checks strobe exclusivity and spacing
   always @(negedge clk) begin
      if (!rst) begin
         if (m_rd) begin
            rd_addr_q.push_back(m_addr);
            if (m_addr == 4'd8) rd_pending = 1'b1;
         end
         if (m_wr) wr_q.push_back({m_addr, m_wdata});
         if (m_rd || m_wr) begin
            checks++;
            if ((m_rd && m_wr) || prev_strobe || (m_sel !== 1'b1)) begin
               errors++;
               $display("[TB] FAIL strobe_protocol rd=%b wr=%b sel=%b prev=%b required one strobe with sel",
                        m_rd, m_wr, m_sel, prev_strobe);
            end
         end
         prev_strobe = m_rd | m_wr;
      end else begin
         prev_strobe = 1'b0;
      end
   end

   // FIFO pops after the edge on which the bridge captured the head byte
   always @(posedge clk) begin
      if (rd_pending) begin
         rd_pending = 1'b0;
         #1 fifo_ptr++;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         wait_clks(HALF);
         rx[i] = spi_miso;
         spi_sclk = 1'b1;
         wait_clks(HALF);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic spi_frame();
      logic [7:0] b;
      rx_q.delete();
      wr_q.delete();
      rd_addr_q.delete();
      spi_cs_n = 1'b0;
      wait_clks(HALF);
      foreach (tx_q[i]) begin
         spi_byte(tx_q[i], b);
         rx_q.push_back(b);
      end
      wait_clks(HALF);
      spi_cs_n = 1'b1;
      wait_clks(2 * HALF);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      m_intr = 1'b0;
      wait_clks(4);
      checks++;
      if ({spi_miso, spi_irq_n, m_sel, m_rd, m_wr} !== 5'b01000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got miso/irq_n/sel/rd/wr=%b required 01000",
                  {spi_miso, spi_irq_n, m_sel, m_rd, m_wr});
      end
      checks++;
      if ({m_addr, m_wdata} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL reset_bus got addr=%h data=%h required 0/0", m_addr, m_wdata);
      end
      rst = 1'b0;
      wait_clks(6);
   endtask

   task automatic test_write_basic();
      tx_q = '{8'h86, 8'h01, 8'h00, 8'h00, 8'h01, 8'h23};
      spi_frame();
      checks++;
      if (wr_q.size() != 1 || rd_addr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL write_count got wr=%0d rd=%0d required 1/0", wr_q.size(), rd_addr_q.size());
      end else begin
         checks++;
         if (wr_q[0] !== {4'd6, 32'h0000_0123}) begin
            errors++;
            $display("[TB] FAIL write_word got %h required 600000123", wr_q[0]);
         end
      end
   endtask

   task automatic test_read_basic();
      logic [7:0] exp [7];
      regs[1] = 32'hDEAD_BEEF;
      m_intr = 1'b1;
      exp = '{8'h00, 8'h00, 8'h80, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      tx_q = '{8'h01, 8'h01, 8'hFF, 8'h55, 8'hAA, 8'h12, 8'h34};
      spi_frame();
      checks++;
      if (rd_addr_q.size() != 1 || wr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL read_count got rd=%0d wr=%0d required 1/0", rd_addr_q.size(), wr_q.size());
      end
      checks++;
      if (spi_irq_n !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_n got %b required 0", spi_irq_n);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rx_q[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL read_miso byte %0d got %h required %h", i, rx_q[i], exp[i]);
         end
      end
      m_intr = 1'b0;
   endtask

   task automatic test_fifo_burst();
      logic [7:0] exp [7];
      fifo_mem[(fifo_ptr + 0) % 256] = 8'h11;
      fifo_mem[(fifo_ptr + 1) % 256] = 8'h22;
      fifo_mem[(fifo_ptr + 2) % 256] = 8'h33;
      exp = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      tx_q = '{8'h08, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      spi_frame();
      checks++;
      if (rd_addr_q.size() != 3) begin
         errors++;
         $display("[TB] FAIL fifo_reads got %0d required 3", rd_addr_q.size());
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rx_q[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL fifo_miso byte %0d got %h required %h", i, rx_q[i], exp[i]);
         end
      end
   endtask

   task automatic test_abort();
      tx_q = '{8'h85, 8'h01, 8'hCA, 8'hFE};
      spi_frame();
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_write got %0d writes required 0", wr_q.size());
      end
      tx_q = '{8'h85, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
      spi_frame();
      checks++;
      if (wr_q.size() != 1 || wr_q[0] !== {4'd5, 32'hCAFE_BABE}) begin
         errors++;
         $display("[TB] FAIL abort_next_frame got n=%0d first=%h required 1 x 5cafebabe",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 36'h0);
      end
   endtask

   task automatic test_len_zero();
      logic [7:0] acc;
      tx_q = '{8'h83, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      spi_frame();
      checks++;
      if (wr_q.size() != 1 || wr_q[0] !== {4'd3, 32'hAABB_CCDD}) begin
         errors++;
         $display("[TB] FAIL len0_write got n=%0d first=%h required 1 x 3aabbccdd",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 36'h0);
      end
      regs[4] = 32'h0F1E_2D3C;
      tx_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      spi_frame();
      checks++;
      if (rd_addr_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL len0_reads got %0d required 1", rd_addr_q.size());
      end
      acc = 8'h00;
      for (int i = 7; i < 13; i++) acc = acc | rx_q[i];
      checks++;
      if ({rx_q[3], rx_q[4], rx_q[5], rx_q[6], acc} !== {32'h0F1E_2D3C, 8'h00}) begin
         errors++;
         $display("[TB] FAIL len0_read_miso got %h%h%h%h drain_or=%h required 0f1e2d3c drain 00",
                  rx_q[3], rx_q[4], rx_q[5], rx_q[6], acc);
      end
   endtask

   task automatic test_random();
      logic        rw, intr, fifo;
      logic [3:0]  addr;
      logic [7:0]  len, exp_b;
      logic [31:0] word, exp_w;
      int          groups, gsize, payload, ptr0, complete, k, bad;
      for (int it = 0; it < 10; it++) begin
         rw   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 2) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         len  = 8'($urandom_range(0, 3));
         intr = 1'($urandom_range(0, 1));
         fifo = (addr == 4'd8);
         gsize  = fifo ? 1 : 4;
         groups = (len == 8'd0) ? 1 : int'(len);
         ptr0 = fifo_ptr;
         for (int i = 0; i < 8; i++) fifo_mem[(ptr0 + i) % 256] = 8'($urandom);
         regs[addr] = $urandom;
         m_intr = intr;
         tx_q.delete();
         tx_q.push_back({rw, 3'($urandom), addr});
         tx_q.push_back(len);
         payload = rw ? $urandom_range(0, groups * gsize + 2) : groups * gsize + 1 + $urandom_range(0, 2);
         for (int i = 0; i < payload; i++) tx_q.push_back(8'($urandom));
         spi_frame();
         bad = 0;
         if (rw) begin
            complete = payload / gsize;
            if (complete > groups) complete = groups;
            checks++;
            if (wr_q.size() != complete || rd_addr_q.size() != 0) begin
               errors++;
               $display("[TB] FAIL rand_write_count it %0d got wr=%0d rd=%0d required %0d/0",
                        it, wr_q.size(), rd_addr_q.size(), complete);
            end else begin
               for (int j = 0; j < complete; j++) begin
                  exp_w = fifo ? {24'h0, tx_q[2 + j]}
                               : {tx_q[2 + 4*j], tx_q[3 + 4*j], tx_q[4 + 4*j], tx_q[5 + 4*j]};
                  checks++;
                  if (wr_q[j] !== {addr, exp_w}) begin
                     errors++;
                     $display("[TB] FAIL rand_write_data it %0d grp %0d got %h required %h",
                              it, j, wr_q[j], {addr, exp_w});
                  end
               end
            end
            foreach (rx_q[i]) if (rx_q[i] !== 8'h00) bad++;
            checks++;
            if (bad != 0) begin
               errors++;
               $display("[TB] FAIL rand_write_miso it %0d got %0d nonzero bytes required 0", it, bad);
            end
         end else begin
            foreach (rd_addr_q[i]) if (rd_addr_q[i] !== addr) bad++;
            checks++;
            if (rd_addr_q.size() != groups || wr_q.size() != 0 || bad != 0) begin
               errors++;
               $display("[TB] FAIL rand_read_count it %0d got rd=%0d wr=%0d badaddr=%0d required %0d/0/0",
                        it, rd_addr_q.size(), wr_q.size(), bad, groups);
            end
            bad = 0;
            foreach (rx_q[i]) begin
               exp_b = 8'h00;
               if (i == 2) begin
                  exp_b = {intr, 7'h00};
               end else if (i >= 3 && i < 3 + groups * gsize) begin
                  k = i - 3;
                  if (fifo) begin
                     exp_b = fifo_mem[(ptr0 + k) % 256];
                  end else begin
                     word  = regs[addr];
                     exp_b = word[31 - 8*(k % 4) -: 8];
                  end
               end
               if (rx_q[i] !== exp_b) begin
                  bad++;
                  $display("[TB] FAIL rand_read_miso it %0d byte %0d got %h required %h", it, i, rx_q[i], exp_b);
               end
            end
            checks++;
            if (bad != 0) errors++;
         end
      end
      m_intr = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] b, acc;
      int rd_before, wr_before;
      regs[2] = 32'h1357_9BDF;
      m_intr = 1'b1;
      rx_q.delete();
      wr_q.delete();
      rd_addr_q.delete();
      spi_cs_n = 1'b0;
      wait_clks(HALF);
      spi_byte(8'h02, b);
      spi_byte(8'h02, b);
      spi_byte(8'h00, b);
      for (int i = 0; i < 3; i++) begin
         spi_mosi = 1'b0;
         wait_clks(HALF);
         spi_sclk = 1'b1;
         wait_clks(HALF);
         spi_sclk = 1'b0;
      end
      wait_clks(2);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({spi_miso, spi_irq_n, m_sel, m_rd, m_wr, m_addr, m_wdata} !== {5'b01000, 36'h0}) begin
         errors++;
         $display("[TB] FAIL async_reset got miso/irq_n/sel/rd/wr=%b addr=%h data=%h required 01000/0/0",
                  {spi_miso, spi_irq_n, m_sel, m_rd, m_wr}, m_addr, m_wdata);
      end
      rd_before = rd_addr_q.size();
      wr_before = wr_q.size();
      wait_clks(3);
      rst = 1'b0;
      wait_clks(4);
      acc = 8'h00;
      spi_byte(8'h81, b);
      acc = acc | b;
      spi_byte(8'h01, b);
      acc = acc | b;
      spi_byte(8'h12, b);
      acc = acc | b;
      spi_byte(8'h34, b);
      acc = acc | b;
      spi_byte(8'h56, b);
      acc = acc | b;
      spi_byte(8'h78, b);
      acc = acc | b;
      checks++;
      if (rd_addr_q.size() != rd_before || wr_q.size() != wr_before || acc !== 8'h00) begin
         errors++;
         $display("[TB] FAIL post_reset_idle got rd=%0d wr=%0d miso_or=%h required %0d/%0d/00",
                  rd_addr_q.size(), wr_q.size(), acc, rd_before, wr_before);
      end
      spi_cs_n = 1'b1;
      wait_clks(2 * HALF);
      m_intr = 1'b0;
      tx_q = '{8'h84, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      spi_frame();
      checks++;
      if (wr_q.size() != 1 || wr_q[0] !== {4'd4, 32'h1234_5678}) begin
         errors++;
         $display("[TB] FAIL post_reset_frame got n=%0d first=%h required 1 x 412345678",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 36'h0);
      end
   endtask

   // Test sequence
   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      for (int i = 0; i < 256; i++) fifo_mem[i] = 8'h0;
      test_reset();
      test_write_basic();
      test_read_basic();
      test_fifo_burst();
      test_abort();
      test_len_zero();
      test_random();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
